// File: rtl/prbs_test_sequencer.sv
// Purpose: runs one automated PRBS link test (reset, lock, dwell, inject, verify) over 8 lanes.
// Latency: 1 + RESET_CYCLES + 1 + DWELL_CYCLES + 1 + INJ_WINDOW cycles from start to done with instant lock.
// Backpressure: none; start is ignored while busy, a held start re-runs the test from DONE.
module prbs_test_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int DWELL_CYCLES = 40000,
    parameter int INJ_WINDOW   = 256
) (
    input  logic        clk40,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  link_enable,
    input  logic [7:0]  rx_locked,
    input  logic [7:0]  rx_err,
    output logic        link_reset,
    output logic        inject,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_total,
    output logic [7:0]  led_fp
);

    // One shared phase counter, wide enough for the longest phase.
    localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (DWELL_CYCLES > INJ_WINDOW) ? DWELL_CYCLES : INJ_WINDOW;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] INJ_LAST   = CW'(INJ_WINDOW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_WAIT_LOCK, S_RUN, S_INJECT, S_INJ_WAIT, S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    en_q;
    logic [7:0]    fail_q;
    logic [7:0]    seen_q;

    logic [7:0]    err_hits;
    logic [3:0]    pop;
    logic [16:0]   err_sum;
    logic [15:0]   err_next;
    logic [7:0]    fail_run;
    logic [7:0]    fail_lock;
    logic [7:0]    seen_next;
    logic [7:0]    led_inj;
    logic          lock_ok;

    // Next-value terms for the per-lane flags and the saturating error count.
    always_comb begin
        err_hits  = rx_err & en_q;
        pop       = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'b000, err_hits[i]};
        end
        err_sum   = {1'b0, err_total} + {13'd0, pop};
        err_next  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        fail_run  = fail_q | (en_q & (rx_err | ~rx_locked));
        fail_lock = fail_q | (en_q & ~rx_locked);
        seen_next = seen_q | err_hits;
        led_inj   = en_q & seen_next & ~fail_lock;
        lock_ok   = ((rx_locked & en_q) == en_q);
    end

    // Test sequencer FSM with all outputs registered.
    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            en_q       <= 8'd0;
            fail_q     <= 8'd0;
            seen_q     <= 8'd0;
            link_reset <= 1'b0;
            inject     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_total  <= 16'd0;
            led_fp     <= 8'd0;
        end else begin
            inject <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        en_q      <= link_enable;
                        fail_q    <= 8'd0;
                        seen_q    <= 8'd0;
                        err_total <= 16'd0;
                        timeout   <= 1'b0;
                        pass      <= 1'b0;
                        led_fp    <= 8'd0;
                        cnt       <= '0;
                        if (link_enable == 8'd0) begin
                            // Nothing to test: report a failed result immediately.
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= S_RESET;
                            done       <= 1'b0;
                            busy       <= 1'b1;
                            link_reset <= 1'b1;
                        end
                    end
                end
                S_RESET: begin
                    if (cnt == RESET_LAST) begin
                        link_reset <= 1'b0;
                        cnt        <= '0;
                        state      <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_ok) begin
                        cnt   <= '0;
                        state <= S_RUN;
                    end else if (cnt == LOCK_LAST) begin
                        timeout <= 1'b1;
                        fail_q  <= fail_lock;
                        led_fp  <= en_q & seen_q & ~fail_lock;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    fail_q    <= fail_run;
                    err_total <= err_next;
                    if (cnt == DWELL_LAST) begin
                        cnt    <= '0;
                        inject <= 1'b1;
                        state  <= S_INJECT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_INJECT: begin
                    state <= S_INJ_WAIT;
                end
                S_INJ_WAIT: begin
                    fail_q <= fail_lock;
                    seen_q <= seen_next;
                    if (cnt == INJ_LAST) begin
                        led_fp <= led_inj;
                        pass   <= (en_q != 8'd0) && (led_inj == en_q) && !timeout;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// Purpose: directed bench for prbs_test_sequencer with a reactive lane model and result scoreboard.
// Latency: results are compared when done rises; timing checks count observed cycles.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_prbs_test_sequencer;

    localparam int RC = 16;
    localparam int LT = 4096;
    localparam int DW = 64;
    localparam int IW = 16;

    typedef struct packed {
        logic        p;
        logic [7:0]  led;
        logic        to;
        logic [15:0] err;
    } exp_t;

    logic        clk40 = 1'b0;
    logic        reset_n, start, start_sat;
    logic [7:0]  link_enable, rx_locked, rx_err;
    logic        link_reset, inject, busy, done, pass, timeout;
    logic [15:0] err_total;
    logic [7:0]  led_fp;
    logic        s_link_reset, s_inject, s_busy, s_done, s_pass, s_timeout;
    logic [15:0] s_err_total;
    logic [7:0]  s_led_fp;

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];

    // lane model knobs and state
    int         lock_delay = 5;
    int         lock_cnt   = 0;
    int         inj_cnt    = -1;
    logic [7:0] never_lock = 8'h00;
    logic [7:0] inj_resp   = 8'hFF;
    logic [7:0] force_err  = 8'h00;
    bit         hold_lock  = 0;
    bit         use_sat    = 0;
    bit         lr_ever    = 0;

    always #5 clk40 = ~clk40;

    prbs_test_sequencer #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .DWELL_CYCLES(DW), .INJ_WINDOW(IW)) dut (
        .clk40(clk40), .reset_n(reset_n), .start(start), .link_enable(link_enable),
        .rx_locked(rx_locked), .rx_err(rx_err), .link_reset(link_reset), .inject(inject),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_total(err_total), .led_fp(led_fp)
    );

    prbs_test_sequencer #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .DWELL_CYCLES(10000), .INJ_WINDOW(IW)) dut_sat (
        .clk40(clk40), .reset_n(reset_n), .start(start_sat), .link_enable(link_enable),
        .rx_locked(rx_locked), .rx_err(rx_err), .link_reset(s_link_reset), .inject(s_inject),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .err_total(s_err_total), .led_fp(s_led_fp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; afterwards the lane model reacts to the DUT's registered outputs.
    task automatic tick();
        logic lr, ij;
        @(posedge clk40);
        #1;
        lr = use_sat ? s_link_reset : link_reset;
        ij = use_sat ? s_inject : inject;
        if (lr) lr_ever = 1;
        if (hold_lock) begin
            rx_locked = ~never_lock;
        end else if (lr) begin
            rx_locked = 8'h00;
            lock_cnt  = 0;
        end else if (lock_cnt < lock_delay) begin
            lock_cnt++;
            if (lock_cnt == lock_delay) rx_locked = ~never_lock;
        end
        if (ij) inj_cnt = 0;
        else if (inj_cnt >= 0) inj_cnt++;
        rx_err = force_err;
        if (inj_cnt == 3) begin
            rx_err  = rx_err | inj_resp;
            inj_cnt = -1;
        end
    endtask

    task automatic start_test(input logic [7:0] en, input bit sat);
        link_enable = en;
        lr_ever     = 0;
        if (sat) start_sat = 1'b1; else start = 1'b1;
        tick();
        start     = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic wait_link_reset_low(input string tag, output int width);
        width = 0;
        while (link_reset === 1'b1 && width < 200) begin
            width++;
            tick();
        end
        check(tag, width, RC);
    endtask

    task automatic wait_inject();
        int n = 0;
        while (inject !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check("inject_seen", inject, 1'b1);
        tick();
        check("inject_width", inject, 1'b0);
    endtask

    // Waits for done, then pops the expected result and compares it.
    task automatic wait_done(input int budget, output int n);
        exp_t e;
        logic d;
        n = 0;
        d = use_sat ? s_done : done;
        while (d !== 1'b1 && n < budget) begin
            tick();
            n++;
            d = use_sat ? s_done : done;
        end
        check("done_seen", d, 1'b1);
        check("sb_nonempty", (sbq.size() > 0), 1'b1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("pass",      use_sat ? s_pass      : pass,      e.p);
            check("led_fp",    use_sat ? s_led_fp    : led_fp,    e.led);
            check("timeout",   use_sat ? s_timeout   : timeout,   e.to);
            check("err_total", use_sat ? s_err_total : err_total, e.err);
            check("busy_done", use_sat ? s_busy      : busy,      1'b0);
        end
    endtask

    initial begin
        int n, w;
        reset_n = 1'b0; start = 1'b0; start_sat = 1'b0;
        link_enable = 8'h00; rx_locked = 8'h00; rx_err = 8'h00;
        repeat (3) @(posedge clk40);
        #1;
        check("reset_outputs", {link_reset, inject, busy, done, pass, timeout, err_total, led_fp}, 0);
        check("reset_outputs_sat", {s_link_reset, s_inject, s_busy, s_done, s_pass, s_timeout, s_err_total, s_led_fp}, 0);
        reset_n = 1'b1;
        tick();

        // Happy path: all lanes lock and detect the injected error.
        sbq.push_back('{p: 1'b1, led: 8'hFF, to: 1'b0, err: 16'd0});
        start_test(8'hFF, 0);
        check("link_reset_next_cycle", link_reset, 1'b1);
        check("busy_running", busy, 1'b1);
        wait_link_reset_low("link_reset_width", w);
        wait_inject();
        wait_done(200, n);
        check("inj_window_len", n, IW);

        // Instant lock: minimum start-to-done length.
        hold_lock = 1;
        sbq.push_back('{p: 1'b1, led: 8'hFF, to: 1'b0, err: 16'd0});
        start_test(8'hFF, 0);
        wait_done(500, n);
        check("min_test_len", n + 1, 1 + RC + 1 + DW + 1 + IW);
        hold_lock = 0;

        // Missed injection on lane 2.
        inj_resp = 8'hFB;
        sbq.push_back('{p: 1'b0, led: 8'h0B, to: 1'b0, err: 16'd0});
        start_test(8'h0F, 0);
        wait_done(500, n);
        inj_resp = 8'hFF;

        // Lock timeout: lane 1 never locks.
        never_lock = 8'h02;
        sbq.push_back('{p: 1'b0, led: 8'h00, to: 1'b1, err: 16'd0});
        start_test(8'h03, 0);
        wait_link_reset_low("link_reset_width_to", w);
        wait_done(5000, n);
        check("lock_timeout_len", n, LT);
        never_lock = 8'h00;

        // Ten cycles of all-lane errors during RUN.
        sbq.push_back('{p: 1'b0, led: 8'h00, to: 1'b0, err: 16'd80});
        start_test(8'hFF, 0);
        wait_link_reset_low("link_reset_width_err", w);
        repeat (20) tick();
        force_err = 8'hFF;
        repeat (10) tick();
        force_err = 8'h00;
        wait_done(500, n);

        // start and link_enable changes during RUN are ignored.
        sbq.push_back('{p: 1'b1, led: 8'h0F, to: 1'b0, err: 16'd0});
        start_test(8'h0F, 0);
        wait_link_reset_low("link_reset_width_ign", w);
        repeat (20) tick();
        start = 1'b1;
        link_enable = 8'hFF;
        tick();
        start = 1'b0;
        check("busy_after_ignored_start", busy, 1'b1);
        wait_done(500, n);

        // Empty lane mask: immediate failed result, no link reset.
        sbq.push_back('{p: 1'b0, led: 8'h00, to: 1'b0, err: 16'd0});
        start_test(8'h00, 0);
        wait_done(3, n);
        check("en0_done_latency", n, 0);
        check("en0_no_link_reset", lr_ever, 1'b0);

        // Saturating error counter on the long-dwell instance.
        use_sat = 1; hold_lock = 1; force_err = 8'hFF;
        sbq.push_back('{p: 1'b0, led: 8'h00, to: 1'b0, err: 16'hFFFF});
        start_test(8'hFF, 1);
        wait_done(11000, n);
        use_sat = 0; hold_lock = 0; force_err = 8'h00;

        // Asynchronous reset in INJ_WAIT, then a fresh full test.
        start_test(8'hFF, 0);
        wait_inject();
        repeat (4) tick();
        check("busy_before_reset", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {link_reset, inject, busy, done, pass, timeout, err_total, led_fp}, 0);
        #2 reset_n = 1'b1;
        tick();
        check("idle_after_reset", {busy, done}, 2'b00);
        sbq.push_back('{p: 1'b1, led: 8'hFF, to: 1'b0, err: 16'd0});
        start_test(8'hFF, 0);
        check("link_reset_after_rst", link_reset, 1'b1);
        wait_link_reset_low("link_reset_width_rst", w);
        wait_done(500, n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
